// File: rtl/tmds_pkg.sv
// tmds_pkg
// Shared definitions for the TMDS receive channels: the four control-token
// symbols, the alignment state type, the decoded-symbol record and the
// 10b-to-8b decode function used by every channel's symbol decoder.
// No ports (package).

package tmds_pkg;

   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH,
      SLIP,
      WAIT,
      LOCKED
   } tmdsState_e;

   typedef struct packed {
      logic       isCtrl;
      logic       c1;
      logic       c0;
      logic [7:0] data;
   } tmdsSym_t;

   // Undo the transmit-side conditional inversion (bit 9) and XOR/XNOR
   // transition coding (bit 8), and recognise the four control tokens.
   // For a control token the data field is simply whatever the data rule
   // yields; callers qualify it with isCtrl.
   function automatic tmdsSym_t tmdsDecode(input logic [9:0] q);
      tmdsSym_t   sym;
      logic [7:0] d;
      sym = '0;
      d = q[9] ? ~q[7:0] : q[7:0];
      sym.data[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         sym.data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      case (q)
         TMDS_CTRL_00: begin
            sym.isCtrl = 1'b1;
            sym.c1     = 1'b0;
            sym.c0     = 1'b0;
         end
         TMDS_CTRL_01: begin
            sym.isCtrl = 1'b1;
            sym.c1     = 1'b0;
            sym.c0     = 1'b1;
         end
         TMDS_CTRL_10: begin
            sym.isCtrl = 1'b1;
            sym.c1     = 1'b1;
            sym.c0     = 1'b0;
         end
         TMDS_CTRL_11: begin
            sym.isCtrl = 1'b1;
            sym.c1     = 1'b1;
            sym.c0     = 1'b1;
         end
         default: begin
            sym.isCtrl = 1'b0;
            sym.c1     = 1'b0;
            sym.c0     = 1'b0;
         end
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/tmds_decode_align_decode.sv
// tmds_symbol_decode
// Purely combinational TMDS symbol decoder, shared by all three channels.
// Ports:
//   symbol_i  in  10  TMDS symbol, bit 0 first on the wire
//   isCtrl_o  out 1   symbol is one of the four control tokens
//   c1_o      out 1   control bit 1 carried by the token (0 for data)
//   c0_o      out 1   control bit 0 carried by the token (0 for data)
//   data_o    out 8   decoded pixel byte (meaningful only when !isCtrl_o)

module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] symbol_i,
   output logic       isCtrl_o,
   output logic       c1_o,
   output logic       c0_o,
   output logic [7:0] data_o
);

   tmdsSym_t sym;

   // Everything is done by the package function so other channels and
   // any future checker decode symbols exactly the same way.
   assign sym      = tmdsDecode(symbol_i);
   assign isCtrl_o = sym.isCtrl;
   assign c1_o     = sym.c1;
   assign c0_o     = sym.c0;
   assign data_o   = sym.data;

endmodule

// File: rtl/tmds_decode_align.sv
// tmds_decode_align
// One TMDS receive channel after the 1:10 deserializer: hunts for the
// 10-bit word boundary by pulsing Bitslip until a long run of control
// tokens is seen, then decodes each symbol into pixel data / C0 / C1 / DE.
// Optional feature: define TMDS_DEC_STATS_EN to add the Err_cnt lock-loss
// counter port.
// Ports:
//   Pixl_CLK     in  1   recovered pixel clock, rising edge
//   Rst_Posedge  in  1   synchronous active-high reset
//   Tmds_word    in  10  deserialized symbol, bit 0 first serial bit
//   Bitslip      out 1   one-cycle request to shift the word boundary
//   Locked       out 1   word alignment achieved
//   Data_out     out 8   decoded pixel byte (0 unless De)
//   C0, C1       out 1   decoded control bits
//   De           out 1   data enable
//   Err_cnt      out 16  lock-loss count (TMDS_DEC_STATS_EN only)

module tmds_decode_align
   import tmds_pkg::*;
#(
   parameter int CTRL_LOCK_CNT = 64,
   parameter int SEARCH_WINDOW = 2048,
   parameter int SLIP_WAIT     = 16
)(
   input  logic        Pixl_CLK,
   input  logic        Rst_Posedge,
   input  logic [9:0]  Tmds_word,
   output logic        Bitslip,
   output logic        Locked,
   output logic [7:0]  Data_out,
   output logic        C0,
   output logic        C1,
   output logic        De
`ifdef TMDS_DEC_STATS_EN
   ,
   output logic [15:0] Err_cnt
`endif
);

   localparam int RUN_W  = (CTRL_LOCK_CNT > 1) ? $clog2(CTRL_LOCK_CNT) : 1;
   localparam int TMR_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
   localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_LOCK_CNT - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_WINDOW - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

   logic              inIsCtrl;
   logic              inC1;
   logic              inC0;
   logic [7:0]        inData;

   tmdsSym_t          stage1_q;
   tmdsState_e        state_q,  state_d;
   logic [RUN_W-1:0]  run_q,    run_d;
   logic [TMR_W-1:0]  search_q, search_d;
   logic [TMR_W-1:0]  idle_q,   idle_d;
   logic [WAIT_W-1:0] wait_q,   wait_d;
   logic              de_q,     de_d;
   logic [7:0]        data_q,   data_d;
   logic              c0_q,     c0_d;
   logic              c1_q,     c1_d;

   tmds_symbol_decode uDecode (
      .symbol_i (Tmds_word),
      .isCtrl_o (inIsCtrl),
      .c1_o     (inC1),
      .c0_o     (inC0),
      .data_o   (inData)
   );

   // Pipeline stage 1 holds the incoming symbol in decoded form, so the
   // alignment FSM and the output stage both work from the same registered
   // view of the word.
   always_ff @(posedge Pixl_CLK) begin
      if (Rst_Posedge) begin
         stage1_q <= '0;
      end else begin
         stage1_q <= '{isCtrl: inIsCtrl, c1: inC1, c0: inC0, data: inData};
      end
   end

   // Alignment state and its counters. Reset returns to SEARCH with every
   // counter cleared, which also drops any slip that was in progress.
   always_ff @(posedge Pixl_CLK) begin
      if (Rst_Posedge) begin
         state_q  <= SEARCH;
         run_q    <= '0;
         search_q <= '0;
         idle_q   <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         search_q <= search_d;
         idle_q   <= idle_d;
         wait_q   <= wait_d;
      end
   end

   // Next-state logic. In SEARCH the lock test is checked before the
   // window expiry so that a run completing on the last window cycle still
   // locks instead of slipping. Counters saturate rather than wrap; in
   // practice the state transitions clear them before they get there.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      search_d = search_q;
      idle_d   = idle_q;
      wait_d   = wait_q;
      case (state_q)
         SEARCH: begin
            if (stage1_q.isCtrl) begin
               if (run_q != '1) begin
                  run_d = run_q + 1'b1;
               end
            end else begin
               run_d = '0;
            end
            if (search_q != '1) begin
               search_d = search_q + 1'b1;
            end
            if (stage1_q.isCtrl && (run_q == RUN_LAST)) begin
               state_d  = LOCKED;
               run_d    = '0;
               search_d = '0;
               idle_d   = '0;
            end else if (search_q == TMR_LAST) begin
               state_d  = SLIP;
               run_d    = '0;
               search_d = '0;
            end
         end
         SLIP: begin
            state_d = WAIT;
            wait_d  = '0;
         end
         WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d  = SEARCH;
               run_d    = '0;
               search_d = '0;
               wait_d   = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         LOCKED: begin
            if (stage1_q.isCtrl) begin
               idle_d = '0;
            end else if (idle_q == TMR_LAST) begin
               state_d  = SEARCH;
               run_d    = '0;
               search_d = '0;
               idle_d   = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // Stage 2 output values. Everything is gated by the lock status seen
   // while the word sits in stage 1; C0/C1 keep the last token's value
   // across data periods and drop to zero whenever alignment is lost.
   always_comb begin
      de_d   = 1'b0;
      data_d = '0;
      c0_d   = 1'b0;
      c1_d   = 1'b0;
      if (state_q == LOCKED) begin
         if (stage1_q.isCtrl) begin
            c0_d = stage1_q.c0;
            c1_d = stage1_q.c1;
         end else begin
            de_d   = 1'b1;
            data_d = stage1_q.data;
            c0_d   = c0_q;
            c1_d   = c1_q;
         end
      end
   end

   // Pipeline stage 2 output registers.
   always_ff @(posedge Pixl_CLK) begin
      if (Rst_Posedge) begin
         de_q   <= 1'b0;
         data_q <= '0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end else begin
         de_q   <= de_d;
         data_q <= data_d;
         c0_q   <= c0_d;
         c1_q   <= c1_d;
      end
   end

`ifdef TMDS_DEC_STATS_EN
   logic [15:0] errCnt_q;
   logic        lockLost;

   // A lock loss is the only way out of LOCKED, so any LOCKED-to-SEARCH
   // step counts one event. Sticky until reset, saturating at all ones.
   assign lockLost = (state_q == LOCKED) && (state_d == SEARCH);

   always_ff @(posedge Pixl_CLK) begin
      if (Rst_Posedge) begin
         errCnt_q <= '0;
      end else if (lockLost && (errCnt_q != 16'hFFFF)) begin
         errCnt_q <= errCnt_q + 16'd1;
      end
   end

   assign Err_cnt = errCnt_q;
`endif

   // Both flags come straight from the state register, so they are glitch
   // free and Bitslip can never coincide with Locked.
   assign Bitslip  = (state_q == SLIP);
   assign Locked   = (state_q == LOCKED);
   assign De       = de_q;
   assign Data_out = data_q;
   assign C0       = c0_q;
   assign C1       = c1_q;

endmodule
